cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Synthesizable run controller placed between the top-level clock/reset and the CPU core.
- Sequences a parametrised core reset hold, gates execution with a run enable, and counts executed cycles.
- Terminates the run on an explicit halt, a detected PC self-loop (stall), or a cycle budget (timeout), and reports which of these occurred.
- Generalises the fixed "reset for 3 cycles, run for a fixed time" bring-up into configurable hardware with restart capability.

Parameters:
- RST_CYCLES, 3: clocks the core reset is held after start; minimum 1.
- MAX_CYCLES, 2500: RUN-cycle budget before timeout; minimum 1.
- CNT_W, 32: cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.
- PC_W, 32: program counter width.
- STALL_CYCLES, 16: consecutive unchanged-PC RUN cycles that count as a self-loop halt; 0 disables stall detection.
- AUTO_START, 1: 1 = leave IDLE automatically; 0 = wait for start.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-low block reset.
- start, input, 1: single-cycle request to (re)start a run.
- halt, input, 1: core halt indication, sampled in RUN.
- pc, input, PC_W: core program counter, sampled in RUN.
- cpu_rst, output, 1: active-high core reset.
- run, output, 1: core execution enable.
- cycle_cnt, output, CNT_W: RUN cycles elapsed in the current run.
- done, output, 1: run ended by halt or stall; sticky.
- timeout, output, 1: run ended by budget exhaustion; sticky.
- stalled, output, 1: qualifies done; the cause was PC stall.
- state, output, 3: encoded FSM state: IDLE=0, RST_HOLD=1, RUN=2, DONE=3, TIMEOUT=4.

Behaviour:
- Reset:
  - Clock and reset: clk is the only clock. reset is synchronous and active-low; it acts only at a rising edge of clk while reset=0.
  - Reset values: state=IDLE, cpu_rst=1, run=0, cycle_cnt=0, done=0, timeout=0, stalled=0; internal hold, stall counter and PC reference cleared.
  - Reset mid-operation: reset=0 in any state returns the block to IDLE at that edge with the values above. No partial completion flags are left.
- All outputs are registered and change only on clock edges.
- IDLE:
  - cpu_rst=1, run=0.
  - Goes to RST_HOLD on the next edge if AUTO_START=1, otherwise when start=1.
- RST_HOLD:
  - cpu_rst=1, run=0.
  - Entry clears cycle_cnt, done, timeout and stalled.
  - Stays exactly RST_CYCLES clocks, then goes to RUN; cpu_rst falls on that same edge.
- RUN:
  - cpu_rst=0, run=1.
  - cycle_cnt increments by 1 on every edge taken in RUN, including the exiting edge.
  - Termination priority at each edge: halt, then stall, then timeout.
  - halt=1 goes to DONE with done=1, stalled=0.
  - Stall: the first RUN cycle loads the PC reference without counting. Afterwards, pc equal to the reference increments the stall counter, and pc different reloads the reference and clears the counter. When the counter reaches STALL_CYCLES, the block goes to DONE with done=1, stalled=1.
  - Timeout: when cycle_cnt==MAX_CYCLES-1 and neither of the above applies, the block goes to TIMEOUT with timeout=1; cycle_cnt ends at MAX_CYCLES.
  - Simultaneous halt and budget exhaustion resolves to DONE, not TIMEOUT.
- DONE and TIMEOUT:
  - cpu_rst=0, run=0.
  - cycle_cnt and all flags are frozen and sticky.
  - start=1 goes to RST_HOLD and clears the flags. start is ignored in RST_HOLD and RUN.
- cycle_cnt never wraps: it is bounded by MAX_CYCLES.
- Outputs done and timeout are mutually exclusive at all times.

Test Plan:
- Defaults, reset=0 for 3 clocks then 1, halt=0, pc incrementing:
  - cpu_rst=1 through IDLE plus 3 RST_HOLD clocks, then run=1.
  - At the 2500th RUN edge: timeout=1, cycle_cnt=2500, run=0, done=0.
- halt=1 pulsed at the 100th RUN cycle:
  - Next edge: state=DONE, done=1, stalled=0, cycle_cnt=100.
  - Flags hold after halt drops.
- pc held at 0x40 from RUN cycle 10 (STALL_CYCLES=16):
  - Reference loads at cycle 10 and matches on cycles 11 to 26.
  - done=1, stalled=1 when the stall counter reaches 16.
  - A single pc change in between restarts the count.
- MAX_CYCLES=50, halt=1 exactly on the cycle where cycle_cnt=49:
  - Result is DONE, done=1, timeout=0, cycle_cnt=50.
- reset=0 asserted at RUN cycle 30:
  - Next edge: state=IDLE, cpu_rst=1, run=0, cycle_cnt=0.
  - After release, a fresh RST_CYCLES hold is observed.
- AUTO_START=0:
  - Stays in IDLE indefinitely.
  - start pulse: RST_HOLD, then RUN.
  - start during RUN: ignored.
  - start in DONE: new run with flags and cycle_cnt cleared at RST_HOLD entry.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller sitting between board clock/reset and the CPU core: holds the core
// in reset, enables execution, counts RUN cycles and ends the run on halt, stall or budget.
module cpu_run_ctrl #(
  parameter int RST_CYCLES   = 3,
  parameter int MAX_CYCLES   = 2500,
  parameter int CNT_W        = 32,
  parameter int PC_W         = 32,
  parameter int STALL_CYCLES = 16,
  parameter int AUTO_START   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_rst,
  output logic             run,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             timeout,
  output logic             stalled,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_RUN      = 3'd2,
    S_DONE     = 3'd3,
    S_TIMEOUT  = 3'd4
  } state_t;

  localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam bit STALL_EN = (STALL_CYCLES > 0);
  localparam bit AUTO_EN  = (AUTO_START != 0);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_EN ? STALL_W'(STALL_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [PC_W-1:0]    pc_ref_reg, pc_ref_next;
  logic               ref_valid_reg, ref_valid_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               done_reg, done_next;
  logic               timeout_reg, timeout_next;
  logic               stalled_reg, stalled_next;
  logic               cpu_rst_reg, cpu_rst_next;
  logic               run_reg, run_next;
  logic               enter_hold;
  logic               stall_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      hold_reg      <= '0;
      stall_cnt_reg <= '0;
      pc_ref_reg    <= '0;
      ref_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      stalled_reg   <= 1'b0;
      cpu_rst_reg   <= 1'b1;
      run_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      stall_cnt_reg <= stall_cnt_next;
      pc_ref_reg    <= pc_ref_next;
      ref_valid_reg <= ref_valid_next;
      cnt_reg       <= cnt_next;
      done_reg      <= done_next;
      timeout_reg   <= timeout_next;
      stalled_reg   <= stalled_next;
      cpu_rst_reg   <= cpu_rst_next;
      run_reg       <= run_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    stall_cnt_next = stall_cnt_reg;
    pc_ref_next    = pc_ref_reg;
    ref_valid_next = ref_valid_reg;
    cnt_next       = cnt_reg;
    done_next      = done_reg;
    timeout_next   = timeout_reg;
    stalled_next   = stalled_reg;
    enter_hold     = 1'b0;
    stall_hit      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (AUTO_EN || start) enter_hold = 1'b1;
      end
      S_RST_HOLD: begin
        if (hold_reg == HOLD_LAST) state_next = S_RUN;
        else hold_next = hold_reg + 1'b1;
      end
      S_RUN: begin
        cnt_next = cnt_reg + 1'b1;
        // A fresh or changed PC becomes the new reference; only repeats count.
        if (!ref_valid_reg || (pc != pc_ref_reg)) begin
          pc_ref_next    = pc;
          ref_valid_next = 1'b1;
          stall_cnt_next = '0;
        end else if (STALL_EN) begin
          if (stall_cnt_reg == STALL_LAST) stall_hit = 1'b1;
          else stall_cnt_next = stall_cnt_reg + 1'b1;
        end

        if (halt) begin
          state_next   = S_DONE;
          done_next    = 1'b1;
          stalled_next = 1'b0;
        end else if (stall_hit) begin
          state_next   = S_DONE;
          done_next    = 1'b1;
          stalled_next = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = S_TIMEOUT;
          timeout_next = 1'b1;
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (start) enter_hold = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    // Every way into RST_HOLD starts a clean run.
    if (enter_hold) begin
      state_next     = S_RST_HOLD;
      hold_next      = '0;
      stall_cnt_next = '0;
      ref_valid_next = 1'b0;
      cnt_next       = '0;
      done_next      = 1'b0;
      timeout_next   = 1'b0;
      stalled_next   = 1'b0;
    end

    cpu_rst_next = (state_next == S_IDLE) || (state_next == S_RST_HOLD);
    run_next     = (state_next == S_RUN);
  end

  assign state     = state_reg;
  assign cpu_rst   = cpu_rst_reg;
  assign run       = run_reg;
  assign cycle_cnt = cnt_reg;
  assign done      = done_reg;
  assign timeout   = timeout_reg;
  assign stalled   = stalled_reg;

endmodule
